lvds_echo_fpga_top: RTL and testbench
=====================================

Name: lvds_echo_fpga_top

Overview:
- Top of the two-FPGA LVDS echo model, 4-bit link variant.
- Accepts 32-bit flits on a put interface and serializes each flit into 8 nibbles on an internal 4-bit link.
- An internal echo stage (partner FPGA model) returns the nibbles on a second 4-bit link. The flit is reassembled and offered on a get interface.
- Used as a self-contained simulation/bring-up block for the inter-FPGA LVDS path.

Parameters:
- FLIT_W, 32, flit width in bits.
- LINK_W, 4, link width in bits; FLIT_W/LINK_W = 8 nibbles per flit.
- IN_DEPTH, 2, input FIFO depth in flits.
- OUT_DEPTH, 2, output FIFO depth in flits.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  synchronous, active-high reset (reset when 1).
- putFlit0_put  in  32  flit to send.
- EN_putFlit0_put  in  1  put enable.
- RDY_putFlit0_put  out  1  input FIFO not full.
- EN_getFlit0_get  in  1  get (dequeue) enable.
- getFlit0_get  out  32  head of output FIFO; 0 when empty.
- RDY_getFlit0_get  out  1  output FIFO not empty.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high on RST_N.
- Reset: clears both FIFOs, serializer, echo register, deserializer and in-flight counter.
  - Any flit mid-transfer is discarded.
  - After the first edge with RST_N=0: RDY_putFlit0_put=1, RDY_getFlit0_get=0, getFlit0_get=0.
- Put handshake: a flit is enqueued at an edge only when EN_putFlit0_put=1 and RDY_putFlit0_put=1. EN while RDY=0 is ignored with no side effect.
- Get handshake: the head is dequeued at an edge only when EN_getFlit0_get=1 and RDY_getFlit0_get=1. EN while RDY=0 is ignored.
- A FIFO at full never sees an enqueue, because RDY is low.
- Serializer states:
  - IDLE -> SEND when the input FIFO is non-empty and out_count + inflight < OUT_DEPTH.
  - On that edge it pops the FIFO, drives tx_nib = flit[31:28], sets tx_valid=1 and cnt=0.
  - SEND: cnt increments each edge; nibble k = flit[31-4k -: 4], MS nibble first.
  - After nibble 7 it starts the next flit immediately if the start condition holds, otherwise returns to IDLE with tx_valid=0.
- Echo stage: one register on {tx_valid, tx_nib} forms the return link.
- Deserializer: shifts in returned nibbles while valid and counts to 8. On the 8th nibble, {shift[27:0], nib} is enqueued into the output FIFO on the same edge and inflight is decremented.
- inflight counter (0..2): increments at serializer start, decrements at output enqueue. Both on one edge leave it unchanged.
- Credit rule: the out_count + inflight < OUT_DEPTH gate guarantees the output FIFO never overflows and no flit is lost.
- Latency: put accepted at edge E0 with the block idle -> serializer start at E1 -> RDY_getFlit0_get high after E10 (10 cycles).
- Throughput: 1 flit per 8 cycles; ordering preserved; data bit-exact.
- Output FIFO: simultaneous enqueue and dequeue allowed, count unchanged.

Decomposition:
- Shared package: FLIT_W, LINK_W, NIBBLES_PER_FLIT=8, and the serializer state enum {IDLE, SEND}.
- One sub-module, flit_fifo: parameterized synchronous FIFO with depth, full/empty and count outputs. Instantiated twice (input and output).
- Serializer, echo register and deserializer live inline in the top.

Test Plan:
- Reset: hold RST_N=1 for 3 cycles with EN pulses asserted -> RDY_putFlit0_put=1, RDY_getFlit0_get=0, getFlit0_get=0 after release; no flit ever appears.
- Single flit: put 0x98000000 at E0 -> RDY_getFlit0_get rises after E10 with getFlit0_get=0x98000000. Get it -> RDY drops next cycle, output returns to 0.
- Pair: put 0x98000001 then 0xD80FFF01 on consecutive cycles, EN_get held 1 -> both echoed in order, second exactly 8 cycles after first.
- Stream: EN_put=1 every cycle with alternating 0x980000nn / 0xD80FFFnn, nn=0x00..0x14, EN_get=1 -> RDY_put deasserts when the input FIFO is full. Every accepted flit emerges once, in order, unchanged; rejected flits never appear.
- Backpressure: EN_get=0, offer 5 flits -> output holds OUT_DEPTH flits, serializer stalls, input FIFO fills, RDY_put=0. Enable get -> all accepted flits drain in order, none lost.
- Mid-transfer reset: assert RST_N 4 cycles after a put -> reset values immediately after the reset edge; the interrupted flit never appears. A subsequent put 0x12345678 echoes correctly after 10 cycles.

Source files
------------

// File: rtl/lvds_echo_fpga_top_pkg.sv
// Shared widths and serializer state encoding for the LVDS echo model.
package lvds_echo_fpga_top_pkg;

    localparam int FLIT_W           = 32;
    localparam int LINK_W           = 4;
    localparam int NIBBLES_PER_FLIT = FLIT_W / LINK_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } serState_e;

endpackage

// File: rtl/lvds_echo_fpga_top_flit_fifo.sv
// Synchronous FIFO with full/empty/count; push when full and pop when empty are ignored.
module flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lvds_echo_fpga_top.sv
// Two-FPGA LVDS echo model: flits go out as nibbles, bounce off a one-register
// partner model and are reassembled into the output FIFO.
//
// state | meaning
// IDLE  | no flit on the outgoing link, txValid low
// SEND  | driving nibble txCnt of the current flit, MS nibble first
module lvds_echo_fpga_top
    import lvds_echo_fpga_top_pkg::*;
#(
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [FLIT_W-1:0] putFlit0_put,
    input  logic              EN_putFlit0_put,
    output logic              RDY_putFlit0_put,
    input  logic              EN_getFlit0_get,
    output logic [FLIT_W-1:0] getFlit0_get,
    output logic              RDY_getFlit0_get
);

    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
    localparam int SUM_W  = OUT_CW + 1;
    localparam int CNT_W  = $clog2(NIBBLES_PER_FLIT);
    localparam int SH_W   = FLIT_W - LINK_W;

    logic              inPush, inPop, inFull, inEmpty;
    logic [FLIT_W-1:0] inHead;
    logic [IN_CW-1:0]  inCount;

    logic              outPush, outPop, outFull, outEmpty;
    logic [FLIT_W-1:0] outHead;
    logic [OUT_CW-1:0] outCount;
    logic [FLIT_W-1:0] outData;

    serState_e         serState;
    logic [CNT_W-1:0]  txCnt;
    logic [FLIT_W-1:0] txRest;
    logic [LINK_W-1:0] txNib;
    logic              txValid;

    logic              echoValid;
    logic [LINK_W-1:0] echoNib;
    logic [SH_W-1:0]   rxShift;
    logic [CNT_W-1:0]  rxLeft;
    logic [OUT_CW-1:0] inflight;

    logic startOk;
    logic lastNib;
    logic unusedSignals;

    assign RDY_putFlit0_put = !inFull;
    assign RDY_getFlit0_get = !outEmpty;
    assign getFlit0_get     = outEmpty ? '0 : outHead;
    assign inPush           = EN_putFlit0_put && !inFull;
    assign outPop           = EN_getFlit0_get && !outEmpty;
    assign unusedSignals    = ^{inCount, outFull};

    // Credit gate: a flit may only leave once the output FIFO has a slot reserved for it.
    assign startOk = !inEmpty && ((SUM_W'(outCount) + SUM_W'(inflight)) < SUM_W'(OUT_DEPTH));
    assign lastNib = (txCnt == CNT_W'(NIBBLES_PER_FLIT - 1));
    assign inPop   = startOk && ((serState == IDLE) || lastNib);

    assign outPush = echoValid && (rxLeft == '0);
    assign outData = {rxShift, echoNib};

    flit_fifo #(.WIDTH(FLIT_W), .DEPTH(IN_DEPTH)) inFifo (
        .clk      (CLK),
        .rst      (RST_N),
        .push     (inPush),
        .pushData (putFlit0_put),
        .pop      (inPop),
        .headData (inHead),
        .full     (inFull),
        .empty    (inEmpty),
        .count    (inCount)
    );

    flit_fifo #(.WIDTH(FLIT_W), .DEPTH(OUT_DEPTH)) outFifo (
        .clk      (CLK),
        .rst      (RST_N),
        .push     (outPush),
        .pushData (outData),
        .pop      (outPop),
        .headData (outHead),
        .full     (outFull),
        .empty    (outEmpty),
        .count    (outCount)
    );

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            serState <= IDLE;
            txValid  <= 1'b0;
            txNib    <= '0;
            txCnt    <= '0;
            txRest   <= '0;
        end else if (inPop) begin
            serState <= SEND;
            txValid  <= 1'b1;
            txNib    <= inHead[FLIT_W-1 -: LINK_W];
            txRest   <= inHead << LINK_W;
            txCnt    <= '0;
        end else if (serState == SEND) begin
            if (lastNib) begin
                serState <= IDLE;
                txValid  <= 1'b0;
            end else begin
                txCnt  <= txCnt + CNT_W'(1);
                txNib  <= txRest[FLIT_W-1 -: LINK_W];
                txRest <= txRest << LINK_W;
            end
        end
    end

    // Partner echo register and receive side; rxLeft counts down to the final nibble.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            echoValid <= 1'b0;
            echoNib   <= '0;
            rxShift   <= '0;
            rxLeft    <= CNT_W'(NIBBLES_PER_FLIT - 1);
            inflight  <= '0;
        end else begin
            echoValid <= txValid;
            echoNib   <= txNib;
            if (echoValid) begin
                rxShift <= {rxShift[SH_W-LINK_W-1:0], echoNib};
                rxLeft  <= (rxLeft == '0) ? CNT_W'(NIBBLES_PER_FLIT - 1) : rxLeft - CNT_W'(1);
            end
            case ({inPop, outPush})
                2'b10:   inflight <= inflight + OUT_CW'(1);
                2'b01:   inflight <= inflight - OUT_CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_echo_fpga_top.sv
// Scoreboard bench: accepted puts queue their flit, a negedge monitor checks every get.
module tb_lvds_echo_fpga_top;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] putFlit0_put = '0;
    logic        EN_putFlit0_put = 1'b0;
    logic        RDY_putFlit0_put;
    logic        EN_getFlit0_get = 1'b0;
    logic [31:0] getFlit0_get;
    logic        RDY_getFlit0_get;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          monOn = 1'b0;
    logic [31:0] expq[$];
    int          popTimes[$];

    lvds_echo_fpga_top dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .putFlit0_put     (putFlit0_put),
        .EN_putFlit0_put  (EN_putFlit0_put),
        .RDY_putFlit0_put (RDY_putFlit0_put),
        .EN_getFlit0_get  (EN_getFlit0_get),
        .getFlit0_get     (getFlit0_get),
        .RDY_getFlit0_get (RDY_getFlit0_get)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        if (monOn && !RST_N && EN_getFlit0_get && RDY_getFlit0_get) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit actual=%h required=none", getFlit0_get);
            end else begin
                chk("get_data", getFlit0_get, expq.pop_front());
                popTimes.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic putTry(input logic [31:0] d, input int tries, output bit ok);
        EN_putFlit0_put = 1'b1;
        putFlit0_put    = d;
        ok = 1'b0;
        for (int i = 0; i < tries && !ok; i++) begin
            @(negedge CLK);
            if (RDY_putFlit0_put) begin
                expq.push_back(d);
                ok = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        EN_putFlit0_put = 1'b0;
    endtask

    task automatic waitDrain(input int maxCyc, input string nm);
        int i = 0;
        while (expq.size() != 0 && i < maxCyc) begin
            @(posedge CLK);
            #1;
            i++;
        end
        chk({nm, "_drain_pending"}, 32'(expq.size()), 0);
    endtask

    task automatic latencyCheck(input logic [31:0] d, input string nm);
        bit ok;
        putTry(d, 1, ok);
        chk({nm, "_accept"}, 32'(ok), 1);
        repeat (10) @(negedge CLK);
        chk({nm, "_rdy_get_e9"}, 32'(RDY_getFlit0_get), 0);
        @(negedge CLK);
        chk({nm, "_rdy_get_e10"}, 32'(RDY_getFlit0_get), 1);
        chk({nm, "_head"}, getFlit0_get, d);
        @(posedge CLK);
        #1;
        EN_getFlit0_get = 1'b1;
        @(posedge CLK);
        #1;
        EN_getFlit0_get = 1'b0;
        @(negedge CLK);
        chk({nm, "_rdy_get_after"}, 32'(RDY_getFlit0_get), 0);
        chk({nm, "_data_after"}, getFlit0_get, 0);
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] bp [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

    initial begin
        bit          ok;
        int          rej;
        int          acc;
        int          diff;
        logic [31:0] d;

        // Reset held three cycles with both enables asserted.
        RST_N = 1'b1;
        EN_putFlit0_put = 1'b1;
        putFlit0_put = 32'hAAAA5555;
        EN_getFlit0_get = 1'b1;
        tick(3);
        RST_N = 1'b0;
        EN_putFlit0_put = 1'b0;
        EN_getFlit0_get = 1'b0;
        monOn = 1'b1;
        @(negedge CLK);
        chk("rst_rdy_put", 32'(RDY_putFlit0_put), 1);
        chk("rst_rdy_get", 32'(RDY_getFlit0_get), 0);
        chk("rst_get_data", getFlit0_get, 0);
        tick(12);
        @(negedge CLK);
        chk("rst_no_flit", 32'(RDY_getFlit0_get), 0);
        tick(1);

        latencyCheck(32'h98000000, "single");

        // Back-to-back pair with get always enabled: outputs 8 cycles apart.
        EN_getFlit0_get = 1'b1;
        popTimes.delete();
        putTry(32'h98000001, 1, ok);
        chk("pair_accept0", 32'(ok), 1);
        putTry(32'hD80FFF01, 1, ok);
        chk("pair_accept1", 32'(ok), 1);
        waitDrain(60, "pair");
        tick(2);
        chk("pair_pop_count", 32'(popTimes.size()), 2);
        diff = (popTimes.size() >= 2) ? popTimes[1] - popTimes[0] : -1;
        chk("pair_spacing", 32'(diff), 8);

        // Stream: one offer per cycle; accepted at offers 0,1,2,10,18 only.
        rej = 0;
        for (int nn = 0; nn <= 20; nn++) begin
            d = nn[0] ? {24'hD80FFF, 8'(nn)} : {24'h980000, 8'(nn)};
            putTry(d, 1, ok);
            if (!ok) rej++;
        end
        chk("stream_rejects", 32'(rej), 16);
        waitDrain(200, "stream");
        tick(4);

        // Backpressure: output fills, serializer stalls, input fills, fifth flit never taken.
        EN_getFlit0_get = 1'b0;
        tick(2);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            putTry(bp[i], 20, ok);
            acc += int'(ok);
        end
        chk("bp_accepted", 32'(acc), 4);
        @(negedge CLK);
        chk("bp_rdy_put", 32'(RDY_putFlit0_put), 0);
        chk("bp_rdy_get", 32'(RDY_getFlit0_get), 1);
        chk("bp_head", getFlit0_get, 32'h11111111);
        tick(1);
        EN_getFlit0_get = 1'b1;
        waitDrain(100, "bp");
        tick(4);
        EN_getFlit0_get = 1'b0;
        tick(2);

        // Reset lands four cycles after the put, while the flit is on the link.
        putTry(32'hCAFEF00D, 1, ok);
        chk("midrst_accept", 32'(ok), 1);
        tick(3);
        RST_N = 1'b1;
        expq.delete();
        @(negedge CLK);
        chk("midrst_rdy_put", 32'(RDY_putFlit0_put), 1);
        chk("midrst_rdy_get", 32'(RDY_getFlit0_get), 0);
        chk("midrst_get_data", getFlit0_get, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        EN_getFlit0_get = 1'b1;
        tick(20);
        EN_getFlit0_get = 1'b0;
        @(negedge CLK);
        chk("midrst_no_flit", 32'(RDY_getFlit0_get), 0);
        tick(1);
        latencyCheck(32'h12345678, "after_rst");
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
